// File: rtl/serv_ibus_pf_pkg.sv
// Shared types for the serv instruction-bus prefetch buffer.
// State encoding and word-address increment.
package serv_ibus_pf_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    PF      = 3'd2,
    PF_HIT  = 3'd3,
    PF_DROP = 3'd4,
    PF_INV  = 3'd5
  } state_t;

  localparam logic [29:0] WORD_INC = 30'd1;

endpackage

// File: rtl/serv_ibus_prefetch.sv
// Single-entry sequential prefetch buffer between serv ibus and
// Wishbone instruction memory.
module serv_ibus_prefetch
  import serv_ibus_pf_pkg::*;
#(
  parameter logic PREFETCH_EN = 1'b1
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic [31:0] i_cpu_adr,
  input  logic        i_cpu_cyc,
  output logic [31:0] o_cpu_rdt,
  output logic        o_cpu_ack,
  output logic [31:0] o_mem_adr,
  output logic        o_mem_cyc,
  input  logic [31:0] i_mem_rdt,
  input  logic        i_mem_ack,
  input  logic        i_inval
);

  state_t      state, state_d;
  logic [29:0] buf_adr, buf_adr_d;
  logic [31:0] buf_dat, buf_dat_d;
  logic        buf_valid, buf_valid_d;
  logic [29:0] pf_adr, pf_adr_d;
  logic [29:0] dem_adr, dem_adr_d;
  logic        cpu_ack_d;
  logic [31:0] cpu_rdt_d;
  logic        mem_cyc_d;
  logic [31:0] mem_adr_d;

  logic [29:0] cpu_wadr;
  logic        new_req;
  logic        mem_ack;
  logic        hit;
  logic        pf_match;
  logic        unused_adr_lsb;

  assign cpu_wadr       = i_cpu_adr[31:2];
  assign unused_adr_lsb = ^i_cpu_adr[1:0];
  // core drops cyc one cycle after ack, so mask that cycle
  assign new_req  = i_cpu_cyc & ~o_cpu_ack;
  assign mem_ack  = i_mem_ack & o_mem_cyc;
  assign hit      = buf_valid & (buf_adr == cpu_wadr) & ~i_inval;
  assign pf_match = (cpu_wadr == pf_adr) & ~i_inval;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state     <= IDLE;
      buf_adr   <= '0;
      buf_dat   <= '0;
      buf_valid <= 1'b0;
      pf_adr    <= '0;
      dem_adr   <= '0;
      o_cpu_ack <= 1'b0;
      o_cpu_rdt <= '0;
      o_mem_cyc <= 1'b0;
      o_mem_adr <= '0;
    end else begin
      state     <= state_d;
      buf_adr   <= buf_adr_d;
      buf_dat   <= buf_dat_d;
      buf_valid <= buf_valid_d;
      pf_adr    <= pf_adr_d;
      dem_adr   <= dem_adr_d;
      o_cpu_ack <= cpu_ack_d;
      o_cpu_rdt <= cpu_rdt_d;
      o_mem_cyc <= mem_cyc_d;
      o_mem_adr <= mem_adr_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (new_req) begin
          state_d = hit ? PF : FETCH;
        end
      end
      FETCH: begin
        if (mem_ack) begin
          state_d = PREFETCH_EN ? PF : IDLE;
        end
      end
      PF: begin
        if (mem_ack) begin
          state_d = IDLE;
        end else if (new_req) begin
          state_d = pf_match ? PF_HIT : PF_DROP;
        end else if (i_inval) begin
          state_d = PF_INV;
        end
      end
      PF_HIT: begin
        if (mem_ack) begin
          state_d = i_inval ? FETCH : PF;
        end else if (i_inval) begin
          state_d = PF_DROP;
        end
      end
      PF_DROP: begin
        if (mem_ack) begin
          state_d = FETCH;
        end
      end
      PF_INV: begin
        if (mem_ack) begin
          state_d = IDLE;
        end else if (new_req) begin
          state_d = PF_DROP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_ack_d   = 1'b0;
    cpu_rdt_d   = o_cpu_rdt;
    buf_adr_d   = buf_adr;
    buf_dat_d   = buf_dat;
    buf_valid_d = buf_valid & ~i_inval;
    pf_adr_d    = pf_adr;
    dem_adr_d   = dem_adr;
    unique case (state)
      IDLE: begin
        if (new_req && hit) begin
          cpu_ack_d   = 1'b1;
          cpu_rdt_d   = buf_dat;
          buf_valid_d = 1'b0;
          pf_adr_d    = buf_adr + WORD_INC;
        end else if (new_req) begin
          dem_adr_d = cpu_wadr;
        end
      end
      FETCH: begin
        if (mem_ack) begin
          cpu_ack_d = 1'b1;
          cpu_rdt_d = i_mem_rdt;
          pf_adr_d  = dem_adr + WORD_INC;
        end
      end
      PF: begin
        if (mem_ack) begin
          buf_dat_d   = i_mem_rdt;
          buf_adr_d   = pf_adr;
          buf_valid_d = ~i_inval;
        end else if (new_req) begin
          dem_adr_d = cpu_wadr;
        end
      end
      PF_HIT: begin
        if (mem_ack && !i_inval) begin
          cpu_ack_d = 1'b1;
          cpu_rdt_d = i_mem_rdt;
          pf_adr_d  = pf_adr + WORD_INC;
        end else if (i_inval) begin
          dem_adr_d = pf_adr;
        end
      end
      PF_INV: begin
        if (!mem_ack && new_req) begin
          dem_adr_d = cpu_wadr;
        end
      end
      default: ;
    endcase
  end

  // cyc always drops for one cycle after an ack before the next fetch
  always_comb begin
    mem_cyc_d = (state_d != IDLE) & ~mem_ack;
    mem_adr_d = o_mem_adr;
    if (state_d == FETCH) begin
      mem_adr_d = {dem_adr_d, 2'b00};
    end else if (state_d != IDLE) begin
      mem_adr_d = {pf_adr_d, 2'b00};
    end
  end

endmodule

// File: tb/tb_serv_ibus_prefetch.sv
// Directed bench for serv_ibus_prefetch with a latency-programmable
// Wishbone memory model.
module tb_serv_ibus_prefetch;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_cpu_adr;
  logic        i_cpu_cyc;
  logic [31:0] o_cpu_rdt;
  logic        o_cpu_ack;
  logic [31:0] o_mem_adr;
  logic        o_mem_cyc;
  logic [31:0] i_mem_rdt = 32'h0;
  logic        i_mem_ack = 1'b0;
  logic        i_inval;

  int tests = 0;
  int fails = 0;
  int cycles = 0;
  int last_ack_cyc = 0;
  int mem_lat = 3;
  int cnt = 0;
  logic [7:0]  gen = 8'h00;
  logic [31:0] mem_log[$];

  typedef struct {
    logic [31:0] adr;
    int          gap;
    int          lat;
    bit          hit;
    int          nread;
  } vec_t;

  vec_t tbl[5];

  always #5 clk = ~clk;

  serv_ibus_prefetch #(.PREFETCH_EN(1'b1)) dut (
    .clk       (clk),
    .i_rst     (i_rst),
    .i_cpu_adr (i_cpu_adr),
    .i_cpu_cyc (i_cpu_cyc),
    .o_cpu_rdt (o_cpu_rdt),
    .o_cpu_ack (o_cpu_ack),
    .o_mem_adr (o_mem_adr),
    .o_mem_cyc (o_mem_cyc),
    .i_mem_rdt (i_mem_rdt),
    .i_mem_ack (i_mem_ack),
    .i_inval   (i_inval)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    logic [31:0] r;
    case (a)
      32'h0:   r = 32'h0000_0013;
      32'h4:   r = 32'h0010_0093;
      default: r = {a[15:0], ~a[15:0]};
    endcase
    return r ^ {gen, 24'h0};
  endfunction

  function automatic int log_count(input logic [31:0] a);
    int n = 0;
    foreach (mem_log[k]) if (mem_log[k] == a) n++;
    return n;
  endfunction

  function automatic logic [31:0] log_last();
    if (mem_log.size() == 0) return 32'hDEAD_BEEF;
    return mem_log[mem_log.size()-1];
  endfunction

  always @(posedge clk) begin
    cycles <= cycles + 1;
    if (i_rst || !o_mem_cyc || i_mem_ack) begin
      i_mem_ack <= 1'b0;
      cnt       <= 0;
    end else if (cnt >= mem_lat - 1) begin
      i_mem_ack    <= 1'b1;
      i_mem_rdt    <= memf(o_mem_adr);
      last_ack_cyc <= cycles + 1;
      mem_log.push_back(o_mem_adr);
    end else begin
      cnt <= cnt + 1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_fetch(input logic [31:0] adr, input bit hit,
                          input string nm);
    int  req;
    int  ackc;
    int  n;
    bit  got;
    @(negedge clk);
    i_cpu_adr = adr;
    i_cpu_cyc = 1'b1;
    req = cycles;
    got = 1'b0;
    n = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      got = o_cpu_ack;
      n++;
    end
    ackc = cycles;
    check({nm, "/ack"}, {31'b0, got}, 32'd1);
    if (got) begin
      check({nm, "/rdt"}, o_cpu_rdt, memf(adr));
      if (hit) begin
        check({nm, "/hit_lat"}, ackc, req + 1);
      end else begin
        check({nm, "/mem_lat"}, ackc, last_ack_cyc + 1);
        check({nm, "/mem_adr"}, log_last(), adr);
      end
    end
    @(negedge clk);
    check({nm, "/ack_pulse"}, {31'b0, o_cpu_ack}, 32'd0);
    i_cpu_cyc = 1'b0;
  endtask

  task automatic check_reset_outs(input string nm);
    check({nm, "/cpu_ack"}, {31'b0, o_cpu_ack}, 32'd0);
    check({nm, "/cpu_rdt"}, o_cpu_rdt, 32'd0);
    check({nm, "/mem_cyc"}, {31'b0, o_mem_cyc}, 32'd0);
    check({nm, "/mem_adr"}, o_mem_adr, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    int n;
    tbl[0] = '{adr: 32'h0000_0000, gap: 0,  lat: 3, hit: 1'b0, nread: 1};
    tbl[1] = '{adr: 32'h0000_0004, gap: 12, lat: 5, hit: 1'b1, nread: 1};
    tbl[2] = '{adr: 32'h0000_0008, gap: 0,  lat: 5, hit: 1'b0, nread: 1};
    tbl[3] = '{adr: 32'h0000_0100, gap: 0,  lat: 5, hit: 1'b0, nread: 1};
    tbl[4] = '{adr: 32'h0000_000C, gap: 0,  lat: 5, hit: 1'b0, nread: 2};

    i_rst     = 1'b1;
    i_cpu_cyc = 1'b0;
    i_cpu_adr = 32'h0;
    i_inval   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    i_rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      mem_lat = tbl[i].lat;
      repeat (tbl[i].gap) @(negedge clk);
      do_fetch(tbl[i].adr, tbl[i].hit, $sformatf("vec%0d", i));
      check($sformatf("vec%0d/nread", i), log_count(tbl[i].adr),
            tbl[i].nread);
    end

    // buffer holds 0x10, invalidate, memory contents change
    repeat (12) @(negedge clk);
    check("inval/pf_fill", log_last(), 32'h0000_0010);
    i_inval = 1'b1;
    gen = 8'h5A;
    @(negedge clk);
    i_inval = 1'b0;
    do_fetch(32'h0000_0010, 1'b0, "inval");
    check("inval/nread", log_count(32'h10), 2);

    // address wrap on prefetch
    do_fetch(32'hFFFF_FFFC, 1'b0, "wrap");
    repeat (12) @(negedge clk);
    check("wrap/pf_adr", log_last(), 32'h0000_0000);
    do_fetch(32'h0000_0000, 1'b1, "wrap_hit");
    repeat (12) @(negedge clk);
    check("pre_rst/pf_fill", log_last(), 32'h0000_0004);

    // reset in the middle of a demand fetch
    @(negedge clk);
    i_cpu_adr = 32'h0000_0200;
    i_cpu_cyc = 1'b1;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      seen = o_mem_cyc && (o_mem_adr == 32'h200);
      n++;
    end
    check("rst/fetch_seen", {31'b0, seen}, 32'd1);
    i_rst     = 1'b1;
    i_cpu_cyc = 1'b0;
    @(negedge clk);
    check_reset_outs("midrst");
    i_rst = 1'b0;
    do_fetch(32'h0000_0004, 1'b0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
